// File: rtl/plantard_mm_pipe.sv
// plantard_mm_pipe
//   Fully pipelined Plantard modular multiplier, one result per cycle.
//   c = Plantard(a, b) mod q_eff, where b arrives pre-scaled by q^-1 mod 2^2W.
//   q_eff is either a generic modulus (cfg_q) or the sparse form
//   2^(k1+m) - 2^(k2+m) + 1, reduced with shifts and adds only.
//
// Ports
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   cfg_we, cfg_mode, cfg_q,
//   cfg_k1, cfg_k2, cfg_m      config write; accepted only while idle with no input
//   cfg_err                    sticky flag: a config write was rejected
//   in_valid/in_ready,
//   in_a, in_b, in_tag         operand handshake, operands and sideband tag
//   out_valid/out_ready,
//   out_c, out_tag             result handshake, result in [0, q) and its tag
//   busy                       any stage (including the output register) holds an op
//
// Pipeline: S1 partial products, S2 sum mod 2^2W, S3 take upper half,
// S4 (T*q + q) >> W, S5 final correction, then the output register.
// Every register advances on the single global enable en = !out_valid | out_ready.

module plantard_mm_pipe #(
    parameter int W     = 64,
    parameter int TAG_W = 4,
    parameter int KW    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic             cfg_mode,
    input  logic [W-1:0]     cfg_q,
    input  logic [KW-1:0]    cfg_k1,
    input  logic [KW-1:0]    cfg_k2,
    input  logic [KW-1:0]    cfg_m,
    output logic             cfg_err,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [2*W-1:0]   in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_c,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int HW  = W / 2;
    localparam int W2  = 2 * W;
    localparam int NPP = 7;

    function automatic logic [W-1:0] sparse_q(input logic [KW:0] s1, input logic [KW:0] s2);
        logic [W2:0] one;
        one = (W2+1)'(1);
        return W'((one << s1) - (one << s2) + one);
    endfunction

    // U lies in [0, q]; only U == q needs folding back to 0.
    function automatic logic [W-1:0] final_reduce(input logic [W:0] u, input logic [W-1:0] q);
        return (u == {1'b0, q}) ? '0 : u[W-1:0];
    endfunction

    logic en;
    logic vld_p1, vld_p2, vld_p3, vld_p4, vld_p5;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign busy     = vld_p1 | vld_p2 | vld_p3 | vld_p4 | vld_p5 | out_valid;

    logic          mode_r;
    logic [W-1:0]  q_r;
    logic [KW:0]   s1_r, s2_r;
    logic [KW:0]   s1_next, s2_next;
    logic          cfg_ok;

    assign cfg_ok  = cfg_we && !busy && !in_valid;
    assign s1_next = (KW+1)'(cfg_k1) + (KW+1)'(cfg_m);
    assign s2_next = (KW+1)'(cfg_k2) + (KW+1)'(cfg_m);

    // Reset config is sparse with all shifts 0, i.e. q_eff = 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_r  <= 1'b0;
            q_r     <= W'(1);
            s1_r    <= '0;
            s2_r    <= '0;
            cfg_err <= 1'b0;
        end else begin
            if (cfg_ok) begin
                mode_r <= cfg_mode;
                q_r    <= cfg_mode ? cfg_q : sparse_q(s1_next, s2_next);
                s1_r   <= s1_next;
                s2_r   <= s2_next;
            end
            if (cfg_we && !cfg_ok)
                cfg_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            vld_p3    <= 1'b0;
            vld_p4    <= 1'b0;
            vld_p5    <= 1'b0;
            out_valid <= 1'b0;
        end else if (en) begin
            vld_p1    <= in_valid;
            vld_p2    <= vld_p1;
            vld_p3    <= vld_p2;
            vld_p4    <= vld_p3;
            vld_p5    <= vld_p4;
            out_valid <= vld_p5;
        end
    end

    logic [W-1:0]     pp_p1 [NPP];
    logic [TAG_W-1:0] tag_p1, tag_p2, tag_p3, tag_p4, tag_p5;
    logic [W2-1:0]    r_p2;
    logic [W-1:0]     t_p3;
    logic [W:0]       u_p4;
    logic [W-1:0]     c_p5;

    logic [W2-1:0]    r_sum;
    logic [W2:0]      t_ext, tq, u_sum;
    logic [W:0]       u_next;

    // Products whose weight is >= 2^2W vanish mod 2^2W: a_hi * b_q3 is never formed.
    always_comb begin
        r_sum = '0;
        for (int j = 0; j < 4; j++)
            r_sum = r_sum + (W2'(pp_p1[j]) << (j * HW));
        for (int j = 0; j < 3; j++)
            r_sum = r_sum + (W2'(pp_p1[4+j]) << ((j + 1) * HW));
    end

    // Sparse mode: T*q = (T << s1) - (T << s2) + T, no multiplier.
    always_comb begin
        t_ext = (W2+1)'(t_p3);
        if (mode_r)
            tq = (W2+1)'(W2'(t_p3) * W2'(q_r));
        else
            tq = (t_ext << s1_r) - (t_ext << s2_r) + t_ext;
        u_sum  = tq + (W2+1)'(q_r);
        u_next = (W+1)'(u_sum >> W);
    end

    always_ff @(posedge clk) begin
        if (en) begin
            // ---- S1: partial products
            for (int j = 0; j < 4; j++)
                pp_p1[j] <= W'(in_a[0 +: HW]) * W'(in_b[j*HW +: HW]);
            for (int j = 0; j < 3; j++)
                pp_p1[4+j] <= W'(in_a[HW +: HW]) * W'(in_b[j*HW +: HW]);
            tag_p1 <= in_tag;
            // ---- S2: r = a*b mod 2^2W
            r_p2   <= r_sum;
            tag_p2 <= tag_p1;
            // ---- S3: T = upper half of r
            t_p3   <= W'(r_p2 >> W);
            tag_p3 <= tag_p2;
            // ---- S4: U = (T*q + q) >> W
            u_p4   <= u_next;
            tag_p4 <= tag_p3;
            // ---- S5: fold U == q to 0
            c_p5   <= final_reduce(u_p4, q_r);
            tag_p5 <= tag_p4;
        end
    end

    // ---- Output register: data only moves with a valid op so it stays stable under stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_c   <= '0;
            out_tag <= '0;
        end else if (en && vld_p5) begin
            out_c   <= c_p5;
            out_tag <= tag_p5;
        end
    end

endmodule

// File: tb/tb_plantard_mm_pipe.sv
module tb_plantard_mm_pipe;

    localparam int W     = 64;
    localparam int TAG_W = 4;
    localparam int KW    = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cfg_we;
    logic             cfg_mode;
    logic [W-1:0]     cfg_q;
    logic [KW-1:0]    cfg_k1, cfg_k2, cfg_m;
    logic             cfg_err;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_a;
    logic [2*W-1:0]   in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_c;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    plantard_mm_pipe #(.W(W), .TAG_W(TAG_W), .KW(KW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_mode(cfg_mode), .cfg_q(cfg_q),
        .cfg_k1(cfg_k1), .cfg_k2(cfg_k2), .cfg_m(cfg_m), .cfg_err(cfg_err),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_c(out_c), .out_tag(out_tag),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    logic [W-1:0] q_model;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    // Plantard reference: r = a*b mod 2^2W, T = r / 2^W, U = floor((T+1)*q / 2^W), U==q -> 0
    function automatic logic [W-1:0] ref_mm(input logic [W-1:0] a, input logic [2*W-1:0] b,
                                            input logic [W-1:0] q);
        logic [3*W-1:0] prod;
        logic [W:0]     t1;
        logic [2*W+1:0] u;
        prod = (3*W)'(a) * (3*W)'(b);
        t1   = (W+1)'(prod[2*W-1:W]) + (W+1)'(1);
        u    = ((2*W+2)'(t1) * (2*W+2)'(q)) >> W;
        return (u == (2*W+2)'(q)) ? '0 : u[W-1:0];
    endfunction

    function automatic logic [W-1:0] rnd_a();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [2*W-1:0] rnd_b();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic set_cfg(input logic mode, input logic [W-1:0] q,
                           input logic [KW-1:0] k1, input logic [KW-1:0] k2, input logic [KW-1:0] m);
        @(negedge clk);
        cfg_we = 1'b1; cfg_mode = mode; cfg_q = q; cfg_k1 = k1; cfg_k2 = k2; cfg_m = m;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // Waits (bounded) for out_valid with out_ready high; lat counts clock edges waited.
    task automatic wait_out(output logic [W-1:0] c, output logic [TAG_W-1:0] t, output int lat);
        lat = 0;
        out_ready = 1'b1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        c = out_c;
        t = out_tag;
        @(negedge clk);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [2*W-1:0] b, input logic [TAG_W-1:0] tg,
                          output logic [W-1:0] c, output logic [TAG_W-1:0] t, output int lat);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = a; in_b = b; in_tag = tg;
        @(negedge clk);
        in_valid = 1'b0;
        wait_out(c, t, lat);
    endtask

    task automatic stream(input int n_ops, input int rdy_pct, input int vld_pct);
        logic [W-1:0]     exp_c [$];
        logic [TAG_W-1:0] exp_t [$];
        int sent   = 0;
        int got    = 0;
        int budget = 0;
        logic             held = 1'b0;
        logic [W-1:0]     hc   = '0;
        logic [TAG_W-1:0] ht   = '0;
        logic [W-1:0]     a    = '0;
        logic [2*W-1:0]   b    = '0;
        logic [TAG_W-1:0] tg   = '0;
        while (got < n_ops && budget < 20 * n_ops + 100) begin
            @(negedge clk);
            budget++;
            if (held) begin
                chk("stall_vld", out_valid, 1);
                chk("stall_c", out_c, hc);
                chk("stall_tag", out_tag, ht);
            end
            out_ready = ($urandom_range(99) < rdy_pct);
            if (sent < n_ops && $urandom_range(99) < vld_pct) begin
                a = rnd_a(); b = rnd_b(); tg = TAG_W'(sent);
                in_valid = 1'b1; in_a = a; in_b = b; in_tag = tg;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (in_valid && in_ready) begin
                exp_c.push_back(ref_mm(a, b, q_model));
                exp_t.push_back(tg);
                sent++;
            end
            if (out_valid && out_ready) begin
                if (exp_c.size() == 0) begin
                    chk("spurious_out", 1, 0);
                end else begin
                    chk("stream_c", out_c, exp_c.pop_front());
                    chk("stream_tag", out_tag, exp_t.pop_front());
                end
                got++;
                held = 1'b0;
            end else if (out_valid) begin
                held = 1'b1; hc = out_c; ht = out_tag;
            end else begin
                held = 1'b0;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stream_count", got, n_ops);
        @(negedge clk);
        chk("stream_drained", busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0]     c;
        logic [TAG_W-1:0] t;
        logic [W-1:0]     a;
        logic [2*W-1:0]   b;
        int               lat;

        rst_n = 1'b0; cfg_we = 1'b0; cfg_mode = 1'b0; cfg_q = '0;
        cfg_k1 = '0; cfg_k2 = '0; cfg_m = '0;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;
        q_model = W'(1);

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_c", out_c, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cfg_err", cfg_err, 0);
        rst_n = 1'b1;

        // Reset config is q_eff = 1: every result folds to 0
        a = rnd_a(); b = rnd_b();
        run_op(a, b, 4'h5, c, t, lat);
        chk("q1_c", c, ref_mm(a, b, q_model));
        chk("q1_tag", t, 4'h5);

        // Generic q = 3329
        set_cfg(1'b1, 64'd3329, 8'd0, 8'd0, 8'd0);
        q_model = 64'd3329;
        b = 128'd1 << 127;
        run_op(64'd1, b, 4'h3, c, t, lat);
        chk("q3329_half_c", c, 64'd1664);
        chk("q3329_tag", t, 4'h3);
        chk("latency", lat, 5);
        run_op(64'd0, rnd_b(), 4'h1, c, t, lat);
        chk("a_zero", c, 0);
        run_op(rnd_a(), 128'd0, 4'h2, c, t, lat);
        chk("b_zero", c, 0);
        // Wrap boundary: T = 2^64-1 gives U = q, folded to 0
        b = {64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
        run_op(64'd1, b, 4'h4, c, t, lat);
        chk("wrap_c", c, 0);

        // Reset mid-flight
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_a = rnd_a(); in_b = rnd_b(); in_tag = TAG_W'(i + 1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("pre_rst_vld", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_c", out_c, 0);
        chk("midrst_out_tag", out_tag, 0);
        chk("midrst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        q_model = W'(1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_no_out", out_valid, 0);
        end

        // Sparse q = 2^32 - 2^20 + 1, back-to-back
        set_cfg(1'b0, 64'd0, 8'd32, 8'd20, 8'd0);
        q_model = (64'd1 << 32) - (64'd1 << 20) + 64'd1;
        stream(1000, 100, 100);

        // Back-pressure
        stream(500, 50, 80);

        // Config guard
        chk("guard_err_clear", cfg_err, 0);
        a = rnd_a(); b = rnd_b();
        @(negedge clk);
        in_valid = 1'b1; in_a = a; in_b = b; in_tag = 4'h9;
        @(negedge clk);
        in_valid = 1'b0;
        cfg_we = 1'b1; cfg_mode = 1'b1; cfg_q = 64'd7681;
        @(negedge clk);
        cfg_we = 1'b0;
        chk("guard_busy_err", cfg_err, 1);
        wait_out(c, t, lat);
        chk("guard_inflight_c", c, ref_mm(a, b, q_model));
        chk("guard_inflight_tag", t, 4'h9);
        a = rnd_a(); b = rnd_b();
        run_op(a, b, 4'hA, c, t, lat);
        chk("guard_q_unchanged", c, ref_mm(a, b, q_model));

        // cfg_we together with in_valid: config rejected, op still accepted
        a = rnd_a(); b = rnd_b();
        @(negedge clk);
        in_valid = 1'b1; in_a = a; in_b = b; in_tag = 4'hB;
        cfg_we = 1'b1; cfg_mode = 1'b1; cfg_q = 64'd7681;
        @(negedge clk);
        in_valid = 1'b0; cfg_we = 1'b0;
        wait_out(c, t, lat);
        chk("simul_c", c, ref_mm(a, b, q_model));
        chk("simul_tag", t, 4'hB);

        // Idle config write takes effect
        set_cfg(1'b1, 64'd7681, 8'd0, 8'd0, 8'd0);
        q_model = 64'd7681;
        for (int i = 0; i < 4; i++) begin
            a = rnd_a(); b = rnd_b();
            run_op(a, b, TAG_W'(i), c, t, lat);
            chk("idle_cfg_c", c, ref_mm(a, b, q_model));
        end
        chk("err_sticky", cfg_err, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
